pipeline_mem_stage: RTL and testbench

PIPELINE_MEM_STAGE -- requirements
Module: pipeline_mem_stage

---
 rtl/rvcpu_mem_pkg.sv | 52 +++++
 rtl/pipeline_mem_stage_if.sv | 24 ++
 rtl/pipeline_mem_stage_mem_align.sv | 61 ++++++
 rtl/pipeline_mem_stage.sv | 163 ++++++++++++++++
 tb/tb_pipeline_mem_stage.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/rvcpu_mem_pkg.sv
// rvcpu_mem_pkg: load/store encodings, MEM-stage FSM states, strobe masks. rev 1.0
`default_nettype none

package rvcpu_mem_pkg;

   localparam logic [2:0] DM_RD_NONE = 3'd0;
   localparam logic [2:0] DM_RD_LB   = 3'd1;
   localparam logic [2:0] DM_RD_LBU  = 3'd2;
   localparam logic [2:0] DM_RD_LH   = 3'd3;
   localparam logic [2:0] DM_RD_LHU  = 3'd4;
   localparam logic [2:0] DM_RD_LW   = 3'd5;
   localparam logic [2:0] DM_RD_LWU  = 3'd6;
   localparam logic [2:0] DM_RD_LD   = 3'd7;

   localparam logic [1:0] DM_WR_NONE = 2'd0;
   localparam logic [1:0] DM_WR_SB   = 2'd1;
   localparam logic [1:0] DM_WR_SH   = 2'd2;
   localparam logic [1:0] DM_WR_SW   = 2'd3;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   localparam logic [7:0] STRB_BASE_B = 8'h01;
   localparam logic [7:0] STRB_BASE_H = 8'h03;
   localparam logic [7:0] STRB_BASE_W = 8'h0F;

   // Store encoding takes priority when both controls are non-zero.
   function automatic logic is_misaligned(input logic [2:0] rd_ctrl,
                                          input logic [1:0] wr_ctrl,
                                          input logic [2:0] off);
      logic bad;
      bad = 1'b0;
      if (wr_ctrl != DM_WR_NONE) begin
         case (wr_ctrl)
            DM_WR_SH: bad = off[0];
            DM_WR_SW: bad = |off[1:0];
            default:  bad = 1'b0;
         endcase
      end else begin
         case (rd_ctrl)
            DM_RD_LH, DM_RD_LHU: bad = off[0];
            DM_RD_LW, DM_RD_LWU: bad = |off[1:0];
            DM_RD_LD:            bad = |off;
            default:             bad = 1'b0;
         endcase
      end
      return bad;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_mem_stage_if.sv
// pipeline_mem_stage_if: data-memory request/response bus. rev 1.0
`default_nettype none

interface pipeline_mem_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [63:0] dmem_addr;
   logic [63:0] dmem_wdata;
   logic [7:0]  dmem_wstrb;
   logic        dmem_ack;
   logic [63:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      output dmem_ack, dmem_rdata
   );
endinterface

`default_nettype wire

// File: rtl/pipeline_mem_stage_mem_align.sv
// mem_align: store lane replication/strobes and load shift/extension (combinational). rev 1.0
`default_nettype none

module mem_align
   import rvcpu_mem_pkg::*;
(
   input  logic [2:0]  off,
   input  logic [2:0]  rd_ctrl,
   input  logic [1:0]  wr_ctrl,
   input  logic [63:0] st_data,
   input  logic [63:0] ld_raw,
   output logic [63:0] st_lanes,
   output logic [7:0]  st_strb,
   output logic [63:0] ld_data
);

   logic [63:0] w_shifted;

   assign w_shifted = ld_raw >> {off, 3'b000};

   // Strobe shift is evaluated at 8 bits so lanes past byte 7 fall off.
   always_comb begin
      st_lanes = st_data;
      st_strb  = 8'h00;
      case (wr_ctrl)
         DM_WR_SB: begin
            st_lanes = {8{st_data[7:0]}};
            st_strb  = STRB_BASE_B << off;
         end
         DM_WR_SH: begin
            st_lanes = {4{st_data[15:0]}};
            st_strb  = STRB_BASE_H << off;
         end
         DM_WR_SW: begin
            st_lanes = {2{st_data[31:0]}};
            st_strb  = STRB_BASE_W << off;
         end
         default: begin
            st_lanes = st_data;
            st_strb  = 8'h00;
         end
      endcase
   end

   always_comb begin
      ld_data = 64'h0;
      case (rd_ctrl)
         DM_RD_LB:  ld_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
         DM_RD_LBU: ld_data = {56'h0,               w_shifted[7:0]};
         DM_RD_LH:  ld_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
         DM_RD_LHU: ld_data = {48'h0,               w_shifted[15:0]};
         DM_RD_LW:  ld_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
         DM_RD_LWU: ld_data = {32'h0,               w_shifted[31:0]};
         DM_RD_LD:  ld_data = w_shifted;
         default:   ld_data = 64'h0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/pipeline_mem_stage.sv
// pipeline_mem_stage: MEM stage with IDLE/WAIT handshake FSM and WB registers. rev 1.0
// Optional misalignment trap: define RVCPU_MEM_MISALIGN_CHK_EN.
`default_nettype none

module pipeline_mem_stage
   import rvcpu_mem_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] alu_result_EX,
   input  logic [63:0] reg_data2_MEM,
   input  logic [63:0] pc_MEM,
   input  logic [4:0]  rd_MEM,
   input  logic        rf_wr_en_EX,
   input  logic [1:0]  rf_wr_sel_EX,
   input  logic [2:0]  dm_rd_ctrl_EX,
   input  logic [1:0]  dm_wr_ctrl_EX,
   pipeline_mem_stage_if.master dmem,
   output logic [63:0] alu_result_WB,
   output logic [63:0] mem_rdata_WB,
   output logic [63:0] pc_WB,
   output logic [4:0]  rd_WB,
   output logic        rf_wr_en_WB,
   output logic [1:0]  rf_wr_sel_WB,
   output logic        misalign_WB,
   output logic        stall_MEM
);

   logic [0:0]  r_state, w_state_nxt;
   logic [63:0] r_addr, r_wdata, r_pc;
   logic [4:0]  r_rd;
   logic        r_wr_en;
   logic [1:0]  r_wr_sel, r_wr_ctrl;
   logic [2:0]  r_rd_ctrl;

   logic        w_in_wait, w_access_live, w_misalign, w_access, w_req, w_capture;
   logic [2:0]  w_rd_ctrl_live;
   logic [63:0] w_addr, w_wdata, w_pc, w_lanes, w_ld_data;
   logic [4:0]  w_rd;
   logic        w_wr_en;
   logic [1:0]  w_wr_sel, w_wr_ctrl;
   logic [2:0]  w_rd_ctrl;
   logic [7:0]  w_strb;

   assign w_in_wait      = (r_state == ST_WAIT);
   assign w_rd_ctrl_live = (dm_wr_ctrl_EX != DM_WR_NONE) ? DM_RD_NONE : dm_rd_ctrl_EX;
   assign w_access_live  = (dm_rd_ctrl_EX != DM_RD_NONE) || (dm_wr_ctrl_EX != DM_WR_NONE);

`ifdef RVCPU_MEM_MISALIGN_CHK_EN
   assign w_misalign = w_access_live && !w_in_wait &&
                       is_misaligned(w_rd_ctrl_live, dm_wr_ctrl_EX, alu_result_EX[2:0]);
`else
   assign w_misalign = 1'b0;
`endif

   assign w_access  = w_access_live && !w_misalign;
   assign w_capture = !w_in_wait && w_access && !dmem.dmem_ack;

   // While waiting, everything comes from the copy taken on entry to WAIT.
   assign w_addr    = w_in_wait ? r_addr    : alu_result_EX;
   assign w_wdata   = w_in_wait ? r_wdata   : reg_data2_MEM;
   assign w_pc      = w_in_wait ? r_pc      : pc_MEM;
   assign w_rd      = w_in_wait ? r_rd      : rd_MEM;
   assign w_wr_en   = w_in_wait ? r_wr_en   : rf_wr_en_EX;
   assign w_wr_sel  = w_in_wait ? r_wr_sel  : rf_wr_sel_EX;
   assign w_wr_ctrl = w_in_wait ? r_wr_ctrl : dm_wr_ctrl_EX;
   assign w_rd_ctrl = w_in_wait ? r_rd_ctrl : w_rd_ctrl_live;

   mem_align u_mem_align (
      .off      (w_addr[2:0]),
      .rd_ctrl  (w_rd_ctrl),
      .wr_ctrl  (w_wr_ctrl),
      .st_data  (w_wdata),
      .ld_raw   (dmem.dmem_rdata),
      .st_lanes (w_lanes),
      .st_strb  (w_strb),
      .ld_data  (w_ld_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_access && !dmem.dmem_ack) w_state_nxt = ST_WAIT;
         ST_WAIT: if (dmem.dmem_ack)              w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Request is masked by reset, stall is not: it tracks live inputs even in reset.
   always_comb begin
      w_req           = w_in_wait || w_access;
      stall_MEM       = w_req && !dmem.dmem_ack;
      dmem.dmem_req   = reset && w_req;
      dmem.dmem_we    = reset && w_req && (w_wr_ctrl != DM_WR_NONE);
      dmem.dmem_wstrb = (reset && w_req) ? w_strb : 8'h00;
      dmem.dmem_addr  = {w_addr[63:3], 3'b000};
      dmem.dmem_wdata = w_lanes;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr    <= 64'h0;
         r_wdata   <= 64'h0;
         r_pc      <= 64'h0;
         r_rd      <= 5'h0;
         r_wr_en   <= 1'b0;
         r_wr_sel  <= 2'h0;
         r_wr_ctrl <= DM_WR_NONE;
         r_rd_ctrl <= DM_RD_NONE;
      end else if (w_capture) begin
         r_addr    <= alu_result_EX;
         r_wdata   <= reg_data2_MEM;
         r_pc      <= pc_MEM;
         r_rd      <= rd_MEM;
         r_wr_en   <= rf_wr_en_EX;
         r_wr_sel  <= rf_wr_sel_EX;
         r_wr_ctrl <= dm_wr_ctrl_EX;
         r_rd_ctrl <= w_rd_ctrl_live;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alu_result_WB <= 64'h0;
         mem_rdata_WB  <= 64'h0;
         pc_WB         <= 64'h0;
         rd_WB         <= 5'h0;
         rf_wr_en_WB   <= 1'b0;
         rf_wr_sel_WB  <= 2'h0;
      end else if (stall_MEM) begin
         rd_WB         <= 5'h0;
         rf_wr_en_WB   <= 1'b0;
      end else begin
         alu_result_WB <= w_addr;
         mem_rdata_WB  <= w_ld_data;
         pc_WB         <= w_pc;
         rd_WB         <= w_rd;
         rf_wr_en_WB   <= w_wr_en && !w_misalign;
         rf_wr_sel_WB  <= w_wr_sel;
      end
   end

`ifdef RVCPU_MEM_MISALIGN_CHK_EN
   logic r_misalign;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_misalign <= 1'b0;
      else        r_misalign <= w_misalign;
   end

   assign misalign_WB = r_misalign;
`else
   assign misalign_WB = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_mem_stage.sv
// tb_pipeline_mem_stage: directed self-checking bench for pipeline_mem_stage. rev 1.0
`default_nettype none

module tb_pipeline_mem_stage;

   logic        clk;
   logic        reset;
   logic [63:0] alu_result_EX, reg_data2_MEM, pc_MEM;
   logic [4:0]  rd_MEM;
   logic        rf_wr_en_EX;
   logic [1:0]  rf_wr_sel_EX;
   logic [2:0]  dm_rd_ctrl_EX;
   logic [1:0]  dm_wr_ctrl_EX;
   logic [63:0] alu_result_WB, mem_rdata_WB, pc_WB;
   logic [4:0]  rd_WB;
   logic        rf_wr_en_WB, misalign_WB, stall_MEM;
   logic [1:0]  rf_wr_sel_WB;

   int checks = 0;
   int errors = 0;

   pipeline_mem_stage_if dmem_bus ();

   pipeline_mem_stage dut (
      .clk           (clk),
      .reset         (reset),
      .alu_result_EX (alu_result_EX),
      .reg_data2_MEM (reg_data2_MEM),
      .pc_MEM        (pc_MEM),
      .rd_MEM        (rd_MEM),
      .rf_wr_en_EX   (rf_wr_en_EX),
      .rf_wr_sel_EX  (rf_wr_sel_EX),
      .dm_rd_ctrl_EX (dm_rd_ctrl_EX),
      .dm_wr_ctrl_EX (dm_wr_ctrl_EX),
      .dmem          (dmem_bus),
      .alu_result_WB (alu_result_WB),
      .mem_rdata_WB  (mem_rdata_WB),
      .pc_WB         (pc_WB),
      .rd_WB         (rd_WB),
      .rf_wr_en_WB   (rf_wr_en_WB),
      .rf_wr_sel_WB  (rf_wr_sel_WB),
      .misalign_WB   (misalign_WB),
      .stall_MEM     (stall_MEM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [63:0] addr, input logic [63:0] data, input logic [63:0] pc,
                        input logic [4:0] rd, input logic wen, input logic [1:0] sel,
                        input logic [2:0] rdc, input logic [1:0] wrc);
      alu_result_EX = addr;
      reg_data2_MEM = data;
      pc_MEM        = pc;
      rd_MEM        = rd;
      rf_wr_en_EX   = wen;
      rf_wr_sel_EX  = sel;
      dm_rd_ctrl_EX = rdc;
      dm_wr_ctrl_EX = wrc;
   endtask

   initial begin
      reset = 1'b0;
      drive(64'h0, 64'h0, 64'h0, 5'd0, 1'b0, 2'd0, 3'd0, 2'd0);
      dmem_bus.dmem_ack   = 1'b0;
      dmem_bus.dmem_rdata = 64'h0;
      #2;
      chk("rst_alu_wb",  alu_result_WB, 64'h0);
      chk("rst_wen_wb",  {63'h0, rf_wr_en_WB}, 64'h0);
      chk("rst_req",     {63'h0, dmem_bus.dmem_req}, 64'h0);
      chk("rst_stall",   {63'h0, stall_MEM}, 64'h0);
      tick();
      reset = 1'b1;

      // SB at 0x1003, zero-wait
      drive(64'h1003, 64'hAB, 64'h100, 5'd0, 1'b0, 2'd0, 3'd0, 2'd1);
      dmem_bus.dmem_ack = 1'b1;
      #1;
      chk("sb_addr",  dmem_bus.dmem_addr, 64'h1000);
      chk("sb_wstrb", {56'h0, dmem_bus.dmem_wstrb}, 64'h08);
      chk("sb_wdata", dmem_bus.dmem_wdata, 64'hABAB_ABAB_ABAB_ABAB);
      chk("sb_we",    {63'h0, dmem_bus.dmem_we}, 64'h1);
      chk("sb_stall", {63'h0, stall_MEM}, 64'h0);
      tick();
      chk("sb_pc_wb",  pc_WB, 64'h100);
      chk("sb_alu_wb", alu_result_WB, 64'h1003);

      // LB at 0x2005 with ack on the fourth cycle
      drive(64'h2005, 64'h12, 64'h104, 5'd5, 1'b1, 2'd1, 3'd1, 2'd0);
      dmem_bus.dmem_ack   = 1'b0;
      dmem_bus.dmem_rdata = 64'h0000_8000_0000_0000;
      #1;
      chk("lb_stall0", {63'h0, stall_MEM}, 64'h1);
      chk("lb_req0",   {63'h0, dmem_bus.dmem_req}, 64'h1);
      chk("lb_wstrb0", {56'h0, dmem_bus.dmem_wstrb}, 64'h0);
      tick();
      chk("lb_bub1_rd",  {59'h0, rd_WB}, 64'h0);
      chk("lb_bub1_wen", {63'h0, rf_wr_en_WB}, 64'h0);
      chk("lb_bub1_pc",  pc_WB, 64'h100);
      drive(64'hDEAD_BEEF_0000_0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'h999, 5'd9, 1'b1, 2'd3, 3'd0, 2'd3);
      #1;
      chk("wait_addr",  dmem_bus.dmem_addr, 64'h2000);
      chk("wait_wstrb", {56'h0, dmem_bus.dmem_wstrb}, 64'h0);
      chk("wait_we",    {63'h0, dmem_bus.dmem_we}, 64'h0);
      chk("lb_stall1",  {63'h0, stall_MEM}, 64'h1);
      tick();
      chk("lb_bub2_wen", {63'h0, rf_wr_en_WB}, 64'h0);
      chk("lb_stall2",   {63'h0, stall_MEM}, 64'h1);
      tick();
      chk("lb_bub3_rd",  {59'h0, rd_WB}, 64'h0);
      dmem_bus.dmem_ack = 1'b1;
      #1;
      chk("lb_stall3",   {63'h0, stall_MEM}, 64'h0);
      chk("wait_addr3",  dmem_bus.dmem_addr, 64'h2000);
      tick();
      chk("lb_rdata", mem_rdata_WB, 64'hFFFF_FFFF_FFFF_FF80);
      chk("lb_rd",    {59'h0, rd_WB}, 64'd5);
      chk("lb_wen",   {63'h0, rf_wr_en_WB}, 64'h1);
      chk("lb_pc",    pc_WB, 64'h104);
      chk("lb_alu",   alu_result_WB, 64'h2005);

      // LHU / LH at 0x2006, LD at 0x2000
      drive(64'h2006, 64'h0, 64'h108, 5'd6, 1'b1, 2'd1, 3'd4, 2'd0);
      dmem_bus.dmem_rdata = 64'hBEEF_0000_0000_0000;
      tick();
      chk("lhu_rdata", mem_rdata_WB, 64'h0000_0000_0000_BEEF);
      chk("lhu_rd",    {59'h0, rd_WB}, 64'd6);
      drive(64'h2006, 64'h0, 64'h10C, 5'd6, 1'b1, 2'd1, 3'd3, 2'd0);
      tick();
      chk("lh_rdata", mem_rdata_WB, 64'hFFFF_FFFF_FFFF_BEEF);
      drive(64'h2000, 64'h0, 64'h110, 5'd8, 1'b1, 2'd1, 3'd7, 2'd0);
      dmem_bus.dmem_rdata = 64'h1122_3344_5566_7788;
      tick();
      chk("ld_rdata", mem_rdata_WB, 64'h1122_3344_5566_7788);

      // Non-access with a stray ack
      drive(64'h55, 64'h0, 64'h200, 5'd7, 1'b1, 2'd2, 3'd0, 2'd0);
      #1;
      chk("na_req",   {63'h0, dmem_bus.dmem_req}, 64'h0);
      chk("na_stall", {63'h0, stall_MEM}, 64'h0);
      tick();
      chk("na_alu", alu_result_WB, 64'h55);
      chk("na_rd",  {59'h0, rd_WB}, 64'd7);
      chk("na_sel", {62'h0, rf_wr_sel_WB}, 64'd2);
      chk("na_req_after", {63'h0, dmem_bus.dmem_req}, 64'h0);

`ifdef RVCPU_MEM_MISALIGN_CHK_EN
      drive(64'h3002, 64'h0, 64'h300, 5'd4, 1'b1, 2'd1, 3'd5, 2'd0);
      dmem_bus.dmem_ack = 1'b0;
      #1;
      chk("mis_req",   {63'h0, dmem_bus.dmem_req}, 64'h0);
      chk("mis_stall", {63'h0, stall_MEM}, 64'h0);
      tick();
      chk("mis_flag", {63'h0, misalign_WB}, 64'h1);
      chk("mis_wen",  {63'h0, rf_wr_en_WB}, 64'h0);
      chk("mis_pc",   pc_WB, 64'h300);
      drive(64'h0, 64'h0, 64'h304, 5'd0, 1'b0, 2'd0, 3'd0, 2'd0);
      tick();
      chk("mis_pulse_end", {63'h0, misalign_WB}, 64'h0);
`else
      drive(64'h3006, 64'h0000_0000_CAFE_F00D, 64'h300, 5'd0, 1'b0, 2'd0, 3'd0, 2'd3);
      dmem_bus.dmem_ack = 1'b1;
      #1;
      chk("sw_mis_wstrb", {56'h0, dmem_bus.dmem_wstrb}, 64'hC0);
      chk("sw_mis_wdata", dmem_bus.dmem_wdata, 64'hCAFE_F00D_CAFE_F00D);
      chk("sw_mis_addr",  dmem_bus.dmem_addr, 64'h3000);
      tick();
      chk("sw_mis_flag", {63'h0, misalign_WB}, 64'h0);
`endif

      // Reset while in WAIT
      drive(64'h4000, 64'h0, 64'h400, 5'd3, 1'b1, 2'd1, 3'd5, 2'd0);
      dmem_bus.dmem_ack = 1'b0;
      tick();
      chk("rw_req_wait", {63'h0, dmem_bus.dmem_req}, 64'h1);
      #2;
      reset = 1'b0;
      #1;
      chk("rw_req",   {63'h0, dmem_bus.dmem_req}, 64'h0);
      chk("rw_wstrb", {56'h0, dmem_bus.dmem_wstrb}, 64'h0);
      chk("rw_stall", {63'h0, stall_MEM}, 64'h1);
      chk("rw_pc_wb", pc_WB, 64'h0);
      reset = 1'b1;
      drive(64'h4004, 64'h0, 64'h404, 5'd3, 1'b1, 2'd1, 3'd5, 2'd0);
      dmem_bus.dmem_ack   = 1'b1;
      dmem_bus.dmem_rdata = 64'h8000_0000_0000_0000;
      #1;
      chk("lw_addr", dmem_bus.dmem_addr, 64'h4000);
      tick();
      chk("lw_rdata", mem_rdata_WB, 64'hFFFF_FFFF_8000_0000);
      chk("lw_rd",    {59'h0, rd_WB}, 64'd3);
      chk("lw_pc",    pc_WB, 64'h404);
      drive(64'h4004, 64'h0, 64'h408, 5'd3, 1'b1, 2'd1, 3'd6, 2'd0);
      tick();
      chk("lwu_rdata", mem_rdata_WB, 64'h0000_0000_8000_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
